riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Load-store unit downstream of riscv_decoder; consumes mem_req/mem_we/mem_size, ALU address, rs2 data.
//  Runs the data-memory req/gnt/rvalid handshake, forms byte enables, replicates write data,
//  sign/zero-extends load data, stalls the core until the access completes.
//  Flags misaligned/illegal-size accesses and bus timeouts without touching memory.
// PARAMETERS
//  BUS_TIMEOUT  255  max cycles waiting for gnt or rvalid before bus error; 0 disables timeout
// PORTS
//  clk_i           in   1   clock, all state on rising edge
//  rst_i           in   1   synchronous active-high reset
//  lsu_req_i       in   1   access requested (decoder mem_req_o), held until stall drops
//  lsu_we_i        in   1   1=store, 0=load (decoder mem_we_o)
//  lsu_size_i      in   3   LDST_B=0 H=1 W=2 BU=4 HU=5 (decoder mem_size_o)
//  lsu_addr_i      in   32  byte address from ALU
//  lsu_data_i      in   32  store data (rs2)
//  lsu_stall_req_o out  1   1 = core must hold PC/instruction
//  lsu_data_o      out  32  extended load data, valid in DONE cycle
//  lsu_misalign_o  out  1   1-cycle pulse: misaligned or illegal size, no access made
//  lsu_bus_err_o   out  1   1-cycle pulse: bus timeout
//  data_req_o      out  1   memory request, held until data_gnt_i
//  data_we_o       out  1   memory write enable
//  data_be_o       out  4   byte enables
//  data_addr_o     out  32  word address ({addr[31:2],2'b00})
//  data_wdata_o    out  32  replicated write data
//  data_gnt_i      in   1   memory accepted request
//  data_rvalid_i   in   1   read data valid (earliest cycle after gnt)
//  data_rdata_i    in   32  read data word
// BEHAVIOUR
//  Reset: state=IDLE; data_req_o/we_o=0, be=0, addr/wdata=0, lsu_data_o=0, pulses=0, counter=0.
//  lsu_stall_req_o = lsu_req_i & (state!=DONE); combinational, so it is 1 in the request cycle.
//  IDLE: lsu_req_i=1 -> latch we/size/addr[1:0]/outputs; check alignment:
//    H/HU addr[0]!=0, W addr[1:0]!=0, size in {3,6,7} -> DONE with lsu_misalign_o=1, no data_req_o.
//    else -> REQ. lsu_req_i=0 -> stay.
//  REQ: data_req_o=1, addr/be/wdata/we stable; gnt: store -> DONE, load -> WAIT.
//  WAIT: data_rvalid_i=1 -> capture extended rdata into lsu_data_o, -> DONE.
//  DONE: 1 cycle, stall=0, pulses asserted here only; -> IDLE unconditionally (no re-issue).
//  Minimum latency: store 3 cycles (IDLE,REQ,DONE), load 4 (IDLE,REQ,WAIT,DONE) with immediate gnt/rvalid.
//  Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU addr[1]?4'b1100:4'b0011; W 4'b1111.
//  Write data: B {4{d[7:0]}}; H {2{d[15:0]}}; W d.
//  Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16];
//    B/H sign-extend, BU/HU zero-extend, W unchanged.
//  lsu_data_o holds last load value until next load completes; stores and errors do not change it.
//  Timeout: counter clears on entering REQ and WAIT, increments each cycle there;
//    reaching BUS_TIMEOUT -> DONE with lsu_bus_err_o=1, data_req_o dropped. Counter saturates.
//  data_rvalid_i in IDLE/REQ/DONE ignored; data_gnt_i outside REQ ignored.
//  rst_i mid-access: next edge returns to IDLE, data_req_o=0; late rvalid ignored.
// TESTING
//  LW addr 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF -> data_o=0xDEADBEEF, stall 1 for 3 cycles.
//  LB addr 0x103 rdata 0x80FF_FF7F -> 0xFFFFFF80; LBU -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
//  SB addr 0x101 data 0x12345678 -> be=0010, wdata=0x78787878, gnt delayed 3 cycles, req held steady.
//  LH addr 0x101 and size=3 -> misalign pulse in 2nd cycle, data_req_o never 1, data_o unchanged.
//  BUS_TIMEOUT=4, gnt never -> bus_err pulse after 4 REQ cycles; rst_i in WAIT -> IDLE, rvalid ignored.

Source files
------------

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Brief    : Load-store unit. Runs the req/gnt/rvalid data bus handshake,
//            forms byte enables and write data, and extends load data.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_stall_req_o,
    output logic [31:0] lsu_data_o,
    output logic        lsu_misalign_o,
    output logic        lsu_bus_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam int            CW        = $clog2(BUS_TIMEOUT + 2);
    localparam bit            c_TO_EN   = (BUS_TIMEOUT != 0);
    localparam logic [CW-1:0] c_TO_LAST = (BUS_TIMEOUT == 0) ? '0 : CW'(BUS_TIMEOUT - 1);

    localparam logic [2:0] c_SZ_B  = 3'd0;
    localparam logic [2:0] c_SZ_H  = 3'd1;
    localparam logic [2:0] c_SZ_W  = 3'd2;
    localparam logic [2:0] c_SZ_BU = 3'd4;
    localparam logic [2:0] c_SZ_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_size;
    logic [1:0]    r_off;
    logic          r_req;
    logic [3:0]    r_be;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_ldata;
    logic          r_mis;
    logic          r_berr;

    logic          w_misalign;
    logic          w_timeout;
    logic          w_set_mis;
    logic          w_set_berr;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ldata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign w_timeout = c_TO_EN && (r_cnt >= c_TO_LAST);

    // Alignment and size legality of the incoming request
    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = lsu_data_i;
        case (lsu_size_i)
            c_SZ_B, c_SZ_BU: begin
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_data_i[7:0]}};
            end
            c_SZ_H, c_SZ_HU: begin
                w_misalign = lsu_addr_i[0];
                w_be       = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{lsu_data_i[15:0]}};
            end
            c_SZ_W: begin
                w_misalign = (lsu_addr_i[1:0] != 2'b00);
            end
            default: begin
                w_misalign = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_byte  = data_rdata_i[{r_off, 3'b000} +: 8];
        w_half  = data_rdata_i[{r_off[1], 4'b0000} +: 16];
        w_ldata = data_rdata_i;
        case (r_size)
            c_SZ_B:  w_ldata = {{24{w_byte[7]}}, w_byte};
            c_SZ_BU: w_ldata = {24'b0, w_byte};
            c_SZ_H:  w_ldata = {{16{w_half[15]}}, w_half};
            c_SZ_HU: w_ldata = {16'b0, w_half};
            default: w_ldata = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A grant wins over a timeout that expires in the same cycle
    always_comb begin
        w_next     = r_state;
        w_set_mis  = 1'b0;
        w_set_berr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lsu_req_i) begin
                    if (w_misalign) begin
                        w_next    = S_DONE;
                        w_set_mis = 1'b1;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (data_gnt_i) begin
                    w_next = r_we ? S_DONE : S_WAIT;
                end else if (w_timeout) begin
                    w_next     = S_DONE;
                    w_set_berr = 1'b1;
                end
            end
            S_WAIT: begin
                if (data_rvalid_i) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next     = S_DONE;
                    w_set_berr = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) && ((w_next == S_REQ) || (w_next == S_WAIT))) begin
            r_cnt <= '0;
        end else if (((r_state == S_REQ) || (r_state == S_WAIT)) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_req   <= 1'b0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_ldata <= 32'd0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            r_mis  <= w_set_mis;
            r_berr <= w_set_berr;
            r_req  <= (w_next == S_REQ);
            if ((r_state == S_IDLE) && lsu_req_i) begin
                r_we    <= lsu_we_i;
                r_size  <= lsu_size_i;
                r_off   <= lsu_addr_i[1:0];
                r_be    <= w_be;
                r_addr  <= {lsu_addr_i[31:2], 2'b00};
                r_wdata <= w_wdata;
            end
            if ((r_state == S_WAIT) && data_rvalid_i) begin
                r_ldata <= w_ldata;
            end
        end
    end

    assign lsu_stall_req_o = lsu_req_i & (r_state != S_DONE);
    assign lsu_data_o      = r_ldata;
    assign lsu_misalign_o  = r_mis;
    assign lsu_bus_err_o   = r_berr;
    assign data_req_o      = r_req;
    assign data_we_o       = r_we;
    assign data_be_o       = r_be;
    assign data_addr_o     = r_addr;
    assign data_wdata_o    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Brief    : Directed self-checking bench for riscv_lsu with a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'd0;
    logic [31:0] lsu_addr_i = 32'd0;
    logic [31:0] lsu_data_i = 32'd0;
    logic        lsu_stall_req_o;
    logic [31:0] lsu_data_o;
    logic        lsu_misalign_o;
    logic        lsu_bus_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;

    riscv_lsu #(.BUS_TIMEOUT(TO)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_data_o      (lsu_data_o),
        .lsu_misalign_o  (lsu_misalign_o),
        .lsu_bus_err_o   (lsu_bus_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;
    logic        e_stall = 1'b0;
    logic        e_req = 1'b0;
    logic        e_mis = 1'b0;
    logic        e_berr = 1'b0;
    logic        e_we = 1'b0;
    logic [3:0]  e_be = 4'd0;
    logic [31:0] e_addr = 32'd0;
    logic [31:0] e_wdata = 32'd0;
    logic [31:0] m_data = 32'd0;
    int          stall_cycles = 0;
    int          req_cycles = 0;
    bit          berr_seen = 1'b0;
    bit          mis_seen = 1'b0;
    logic [3:0]  last_be = 4'd0;
    logic [31:0] last_wdata = 32'd0;

    function automatic bit mdl_misalign(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return (a % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] mdl_be(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0, 3'd4: return 4'(1 << (a % 4));
            3'd1, 3'd5: return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] sz, input logic [31:0] d);
        case (sz)
            3'd0, 3'd4: return {24'b0, d[7:0]} * 32'h0101_0101;
            3'd1, 3'd5: return {16'b0, d[15:0]} * 32'h0001_0001;
            default:    return d;
        endcase
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] sz, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * (a % 4));
        case (sz)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd4:    return {24'b0, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd5:    return {16'b0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_exp(input logic st, input logic rq, input logic mi, input logic be);
        e_stall = st;
        e_req   = rq;
        e_mis   = mi;
        e_berr  = be;
    endtask

    always begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            chk("stall", 32'(lsu_stall_req_o), 32'(e_stall));
            chk("data_req", 32'(data_req_o), 32'(e_req));
            chk("misalign", 32'(lsu_misalign_o), 32'(e_mis));
            chk("bus_err", 32'(lsu_bus_err_o), 32'(e_berr));
            chk("lsu_data", lsu_data_o, m_data);
            if (e_req) begin
                chk("be", 32'(data_be_o), 32'(e_be));
                chk("addr", data_addr_o, e_addr);
                chk("wdata", data_wdata_o, e_wdata);
                chk("we", 32'(data_we_o), 32'(e_we));
            end
            if (lsu_stall_req_o) stall_cycles++;
            if (data_req_o) begin
                req_cycles++;
                last_be    = data_be_o;
                last_wdata = data_wdata_o;
            end
            if (lsu_bus_err_o) berr_seen = 1'b1;
            if (lsu_misalign_o) mis_seen = 1'b1;
        end
    end

    // One access from request to the idle cycle after DONE; gnt/rvalid arrive
    // after the given number of empty cycles (>= TO means never).
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd);
        bit mis;
        bit err;
        int n;
        mis = mdl_misalign(sz, a);
        err = 1'b0;
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = a; lsu_data_i = d;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        stall_cycles = 0; req_cycles = 0; berr_seen = 1'b0; mis_seen = 1'b0;
        e_be = mdl_be(sz, a); e_wdata = mdl_wdata(sz, d); e_addr = a & 32'hFFFF_FFFC; e_we = we;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        if (!mis) begin
            n = 0;
            forever begin
                @(negedge clk);
                data_rvalid_i = 1'b1;
                data_gnt_i = (n == gnt_dly);
                set_exp(1'b1, 1'b1, 1'b0, 1'b0);
                if (data_gnt_i) break;
                n++;
                if (n == TO) begin
                    err = 1'b1;
                    break;
                end
            end
            if (!err && !we) begin
                n = 0;
                forever begin
                    @(negedge clk);
                    data_gnt_i = 1'b1;
                    data_rvalid_i = (n == rv_dly);
                    data_rdata_i = data_rvalid_i ? rd : 32'h5A5A_5A5A;
                    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
                    if (data_rvalid_i) break;
                    n++;
                    if (n == TO) begin
                        err = 1'b1;
                        break;
                    end
                end
            end
        end
        @(negedge clk);
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hA5A5_A5A5;
        if (!mis && !err && !we) m_data = mdl_load(sz, a, rd);
        set_exp(1'b0, 1'b0, 1'(mis), 1'(err));
        @(negedge clk);
        lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_be", 32'(data_be_o), 32'h0);
        chk("rst_addr", data_addr_o, 32'h0);
        chk("rst_wdata", data_wdata_o, 32'h0);
        chk("rst_data", lsu_data_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;

        access(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
        chk("lw_lit", lsu_data_o, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", 32'(stall_cycles), 32'd3);

        access(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_FF7F);
        chk("lb_lit", lsu_data_o, 32'hFFFF_FF80);
        access(1'b0, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80FF_FF7F);
        chk("lbu_lit", lsu_data_o, 32'h0000_0080);
        access(1'b0, 3'd5, 32'h102, 32'h0, 0, 0, 32'h80FF_FF7F);
        chk("lhu_lit", lsu_data_o, 32'h0000_80FF);

        access(1'b1, 3'd0, 32'h101, 32'h1234_5678, 2, 0, 32'h0);
        chk("sb_be_lit", 32'(last_be), 32'h2);
        chk("sb_wdata_lit", last_wdata, 32'h7878_7878);
        chk("sb_req_cycles", 32'(req_cycles), 32'd3);
        chk("sb_keeps_data", lsu_data_o, 32'h0000_80FF);

        access(1'b0, 3'd1, 32'h101, 32'h0, 0, 0, 32'hFFFF_FFFF);
        chk("lh_mis_seen", 32'(mis_seen), 32'd1);
        chk("lh_mis_no_req", 32'(req_cycles), 32'd0);
        chk("lh_mis_data", lsu_data_o, 32'h0000_80FF);
        access(1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 32'hFFFF_FFFF);
        chk("sz3_mis_seen", 32'(mis_seen), 32'd1);
        chk("sz3_no_req", 32'(req_cycles), 32'd0);

        access(1'b1, 3'd1, 32'h102, 32'hABCD_1234, 0, 0, 32'h0);
        chk("sh_be_lit", 32'(last_be), 32'hC);
        chk("sh_wdata_lit", last_wdata, 32'h1234_1234);
        access(1'b1, 3'd2, 32'h200, 32'hCAFE_F00D, 1, 0, 32'h0);
        chk("sw_wdata_lit", last_wdata, 32'hCAFE_F00D);
        access(1'b0, 3'd1, 32'h202, 32'h0, 0, 2, 32'h8001_1234);
        chk("lh_lit", lsu_data_o, 32'hFFFF_8001);
        access(1'b0, 3'd0, 32'h200, 32'h0, 0, 1, 32'h1234_5681);
        chk("lb0_lit", lsu_data_o, 32'hFFFF_FF81);

        access(1'b0, 3'd2, 32'h300, 32'h0, 1000, 0, 32'h0);
        chk("to_gnt_berr", 32'(berr_seen), 32'd1);
        chk("to_gnt_req_cycles", 32'(req_cycles), 32'd4);
        chk("to_gnt_data", lsu_data_o, 32'hFFFF_FF81);
        access(1'b0, 3'd2, 32'h304, 32'h0, 0, 1000, 32'h0);
        chk("to_rv_berr", 32'(berr_seen), 32'd1);
        chk("to_rv_data", lsu_data_o, 32'hFFFF_FF81);

        @(negedge clk);
        req_cycles = 0;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h400; lsu_data_i = 32'h0;
        e_be = 4'hF; e_addr = 32'h400; e_wdata = 32'h0; e_we = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        data_gnt_i = 1'b1;
        set_exp(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        data_gnt_i = 1'b0; rst_i = 1'b1; lsu_req_i = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
        m_data = 32'h0;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        #3;
        chk("rst_wait_data", lsu_data_o, 32'h0);
        chk("rst_wait_req_cycles", 32'(req_cycles), 32'd1);

        access(1'b0, 3'd2, 32'h500, 32'h0, 0, 1, 32'h0BAD_F00D);
        chk("post_rst_lw_lit", lsu_data_o, 32'h0BAD_F00D);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
